// File: rtl/pbit_pkg.sv
// rtl/pbit_pkg.sv - shared types, constants and saturating add for the p-bit clamp sequencer
package pbit_pkg;

    localparam int H_W_DEF = 8;

    typedef logic signed [H_W_DEF-1:0] h_word_t;

    localparam h_word_t H_MAX = {1'b0, {(H_W_DEF-1){1'b1}}};
    localparam h_word_t H_MIN = {1'b1, {(H_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } clamp_state_t;

    // Widened add, then clip into the signed range of a w-bit word.
    function automatic int sat_add(input int a, input int b, input int w);
        int hi;
        int lo;
        int s;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        s  = a + b;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/pbit_clamp_lane.sv
// rtl/pbit_clamp_lane.sv - combinational clamp of one bias word toward its target extreme
module pbit_clamp_lane
    import pbit_pkg::*;
#(
    parameter int H_W = 8
) (
    input  logic signed [H_W-1:0] i_h,
    input  logic                  i_pat,
    input  logic                  i_mask,
    input  logic        [H_W-2:0] i_s,
    input  clamp_state_t          i_state,
    output logic signed [H_W-1:0] o_h
);

    localparam logic signed [H_W-1:0] L_MAX = {1'b0, {(H_W-1){1'b1}}};
    localparam logic signed [H_W-1:0] L_MIN = {1'b1, {(H_W-1){1'b0}}};

    int w_delta;
    int w_sum;

    always_comb begin
        w_delta = i_pat ? -int'(i_s) : int'(i_s);
        w_sum   = sat_add(int'(i_h), w_delta, H_W);
        o_h     = i_h;
        if (i_mask) begin
            case (i_state)
                RAMP_UP, RAMP_DOWN: o_h = H_W'(w_sum);
                HOLD:               o_h = i_pat ? L_MIN : L_MAX;
                default:            o_h = i_h;
            endcase
        end
    end

endmodule

// File: rtl/pbit_clamp_sequencer.sv
// rtl/pbit_clamp_sequencer.sv - ramp/hold/ramp clamp of a p-bit window toward a handshaked pattern
module pbit_clamp_sequencer
    import pbit_pkg::*;
#(
    parameter int N_PBITS    = 91,
    parameter int H_W        = 8,
    parameter int CLAMP_BASE = 45,
    parameter int N_CLAMP    = 8,
    parameter int HOLD_W     = 16,
    parameter int STEP_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [H_W-1:0]    i_h [N_PBITS],
    input  logic        [N_CLAMP-1:0] i_pat,
    input  logic        [N_CLAMP-1:0] i_pat_mask,
    input  logic                     i_pat_valid,
    output logic                     o_pat_ready,
    input  logic        [HOLD_W-1:0] i_hold_cycles,
    input  logic        [STEP_W-1:0] i_ramp_step,
    input  logic                     i_abort,
    output logic signed [H_W-1:0]    o_h_clamped [N_PBITS],
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int              S_W  = H_W - 1;
    localparam logic [S_W-1:0]  SMAX = '1;

    if (CLAMP_BASE + N_CLAMP > N_PBITS) begin : g_bad_cfg
        $error("clamp window exceeds p-bit vector");
    end

    clamp_state_t          r_state;
    logic [S_W-1:0]        r_s;
    logic [HOLD_W-1:0]     r_cnt;
    logic [HOLD_W-1:0]     r_hold;
    logic [STEP_W-1:0]     r_step;
    logic [N_CLAMP-1:0]    r_pat;
    logic [N_CLAMP-1:0]    r_mask;
    logic                  r_done;
    logic signed [H_W-1:0] r_h_clamped [N_PBITS];

    logic                  w_accept;
    logic [S_W-1:0]        w_s_next;
    logic [31:0]           w_up;
    logic signed [H_W-1:0] w_lane_h [N_CLAMP];
    logic signed [H_W-1:0] w_h_next [N_PBITS];

    assign w_accept = i_pat_valid && (r_state == IDLE) && !i_abort;

    // Lanes see the strength being written this cycle, so the first ramp
    // output already carries one step.
    always_comb begin
        w_s_next = r_s;
        w_up     = 32'(r_s) + 32'(r_step);
        case (r_state)
            RAMP_UP: begin
                if (r_step == '0 || w_up >= 32'(SMAX)) begin
                    w_s_next = SMAX;
                end else begin
                    w_s_next = S_W'(w_up);
                end
            end
            RAMP_DOWN: begin
                if (r_step == '0 || 32'(r_step) >= 32'(r_s)) begin
                    w_s_next = '0;
                end else begin
                    w_s_next = r_s - S_W'(r_step);
                end
            end
            default: w_s_next = r_s;
        endcase
    end

    for (genvar k = 0; k < N_CLAMP; k++) begin : g_lane
        pbit_clamp_lane #(
            .H_W (H_W)
        ) u_lane (
            .i_h     (i_h[CLAMP_BASE+k]),
            .i_pat   (r_pat[k]),
            .i_mask  (r_mask[k]),
            .i_s     (w_s_next),
            .i_state (r_state),
            .o_h     (w_lane_h[k])
        );
    end

    always_comb begin
        w_h_next = i_h;
        for (int k = 0; k < N_CLAMP; k++) begin
            w_h_next[CLAMP_BASE+k] = w_lane_h[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PBITS; i++) begin
                r_h_clamped[i] <= '0;
            end
        end else begin
            r_h_clamped <= w_h_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_step  <= '0;
            r_pat   <= '0;
            r_mask  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pat   <= i_pat;
                        r_mask  <= i_pat_mask;
                        r_hold  <= i_hold_cycles;
                        r_step  <= i_ramp_step;
                        r_s     <= '0;
                        r_cnt   <= '0;
                        r_state <= RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    r_s   <= w_s_next;
                    r_cnt <= '0;
                    if (w_s_next == SMAX) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_cnt == r_hold) begin
                        r_state <= RAMP_DOWN;
                    end else begin
                        r_cnt <= r_cnt + HOLD_W'(1);
                    end
                end
                RAMP_DOWN: begin
                    r_s <= w_s_next;
                    if (w_s_next == '0) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Abort overrides every transition above, including completion.
            if (i_abort && r_state != IDLE) begin
                r_state <= IDLE;
                r_s     <= '0;
                r_cnt   <= '0;
                r_done  <= 1'b0;
            end
        end
    end

    assign o_h_clamped = r_h_clamped;
    assign o_pat_ready = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;

endmodule

// File: tb/tb_pbit_clamp_sequencer.sv
// tb/tb_pbit_clamp_sequencer.sv - directed self-checking bench for pbit_clamp_sequencer
module tb_pbit_clamp_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [7:0] h  [91];
    logic signed [7:0] hc [91];
    logic [7:0]        pat;
    logic [7:0]        pat_mask;
    logic              pat_valid;
    logic              pat_ready;
    logic [15:0]       hold_cycles;
    logic [3:0]        ramp_step;
    logic              abort;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    int ramp_exp [19] = '{115, 127, 127, 127, 127, 127, 127, 127, 127, 127,
                          127, 127, 127, 127, 127, 127, 122, 107, 100};

    pbit_clamp_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_h           (h),
        .i_pat         (pat),
        .i_pat_mask    (pat_mask),
        .i_pat_valid   (pat_valid),
        .o_pat_ready   (pat_ready),
        .i_hold_cycles (hold_cycles),
        .i_ramp_step   (ramp_step),
        .i_abort       (abort),
        .o_h_clamped   (hc),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ramp_h();
        for (int i = 0; i < 91; i++) begin
            h[i] = 8'(i - 45);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ready"}, int'(pat_ready), 1);
    endtask

    initial begin
        rst_n       = 1'b0;
        pat         = '0;
        pat_mask    = '0;
        pat_valid   = 1'b0;
        hold_cycles = '0;
        ramp_step   = '0;
        abort       = 1'b0;
        set_ramp_h();

        #2;
        check("rst_hc0", int'(hc[0]), 0);
        check("rst_hc90", int'(hc[90]), 0);
        check("rst_done", int'(done), 0);
        check_idle("rst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("pass_hc0", int'(hc[0]), -45);
        check("pass_hc90", int'(hc[90]), 45);
        check("pass_hc46", int'(hc[46]), 1);
        check_idle("pass");

        // Alternating pattern, no ramp, four hold cycles; valid stays high throughout.
        for (int i = 0; i < 91; i++) h[i] = '0;
        pat = 8'b1010_1010; pat_mask = 8'hFF; ramp_step = 4'd0; hold_cycles = 16'd3;
        pat_valid = 1'b1;
        tick();
        check("alt_acc_busy", int'(busy), 1);
        check("alt_acc_ready", int'(pat_ready), 0);
        check("alt_acc_hc45", int'(hc[45]), 0);
        tick();
        check("alt_up_hc45", int'(hc[45]), 127);
        check("alt_up_hc46", int'(hc[46]), -127);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("alt_hold%0d_hc45", k), int'(hc[45]), 127);
            check($sformatf("alt_hold%0d_hc46", k), int'(hc[46]), -128);
            check($sformatf("alt_hold%0d_hc52", k), int'(hc[52]), -128);
            check($sformatf("alt_hold%0d_hc53", k), int'(hc[53]), 0);
            check($sformatf("alt_hold%0d_done", k), int'(done), 0);
        end
        tick();
        check("alt_end_hc45", int'(hc[45]), 0);
        check("alt_end_hc46", int'(hc[46]), 0);
        check("alt_end_done", int'(done), 1);
        check_idle("alt_end");
        tick();
        check("re_acc_busy", int'(busy), 1);
        check("re_acc_done", int'(done), 0);
        pat_valid = 1'b0;
        repeat (5) tick();
        check("re_mid_busy", int'(busy), 1);
        tick();
        check("re_end_done", int'(done), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("once%0d_busy", k), int'(busy), 0);
            check($sformatf("once%0d_done", k), int'(done), 0);
        end

        // Stepped ramp on a single masked channel with saturation both ways.
        set_ramp_h();
        h[45] = 8'sd100;
        pat = 8'h00; pat_mask = 8'h01; ramp_step = 4'd15; hold_cycles = 16'd0;
        pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
        for (int k = 0; k < 19; k++) begin
            tick();
            check($sformatf("ramp%0d_hc45", k), int'(hc[45]), ramp_exp[k]);
            check($sformatf("ramp%0d_done", k), int'(done), (k == 18) ? 1 : 0);
            check($sformatf("ramp%0d_busy", k), int'(busy), (k == 18) ? 0 : 1);
        end
        check("mask_hc44", int'(hc[44]), -1);
        check("mask_hc46", int'(hc[46]), 1);
        check("mask_hc52", int'(hc[52]), 7);

        // Abort in HOLD, then abort racing a new pattern in IDLE.
        set_ramp_h();
        pat = 8'hFF; pat_mask = 8'hFF; ramp_step = 4'd0; hold_cycles = 16'd10;
        pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
        tick();
        check("ab_up_hc45", int'(hc[45]), -127);
        tick();
        check("ab_hold_hc45", int'(hc[45]), -128);
        check("ab_hold_hc46", int'(hc[46]), -128);
        abort = 1'b1;
        tick();
        check_idle("ab_next");
        check("ab_next_done", int'(done), 0);
        check("ab_next_hc45", int'(hc[45]), -128);
        pat_valid = 1'b1;
        tick();
        check("ab_race_busy", int'(busy), 0);
        check("ab_race_done", int'(done), 0);
        check("ab_race_hc45", int'(hc[45]), 0);
        check("ab_race_hc46", int'(hc[46]), 1);
        abort = 1'b0;
        pat_valid = 1'b0;
        tick();
        check("ab_after_busy", int'(busy), 0);

        // Async reset in the middle of a slow ramp.
        pat = 8'hFF; pat_mask = 8'hFF; ramp_step = 4'd1; hold_cycles = 16'd0;
        pat_valid = 1'b1;
        tick();
        pat_valid = 1'b0;
        repeat (3) tick();
        check("rr_up_hc45", int'(hc[45]), -3);
        check("rr_up_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_hc45", int'(hc[45]), 0);
        check("rr_hc0", int'(hc[0]), 0);
        check("rr_done", int'(done), 0);
        check_idle("rr");
        tick();
        rst_n = 1'b1;
        tick();
        check("rr_rel_hc0", int'(hc[0]), -45);
        check("rr_rel_hc45", int'(hc[45]), 0);
        check_idle("rr_rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
